// File: rtl/wb_coef_calc_if.sv
// wb_ctrl_if: control bundle from the white-balance CSR block to the
// coefficient engine (mode, calibration strobe, manual coefficient load).
interface wb_ctrl_if;
    logic [1:0]  mode;
    logic        cal_stb;
    logic [1:0]  man_sel;
    logic [31:0] man_coef;
    logic        man_lock;

    modport master (
        output mode,
        output cal_stb,
        output man_sel,
        output man_coef,
        output man_lock
    );

    modport slave (
        input  mode,
        input  cal_stb,
        input  man_sel,
        input  man_coef,
        input  man_lock
    );
endinterface

// File: rtl/wb_coef_calc.sv
// wb_coef_calc: white-balance coefficient engine.
// Snoops the RGB stream, accumulates per-channel frame sums and derives
// gray-world gains G/R and G/B with a serial restoring divider; also holds
// manual coefficients and a registered output mux selected by mode.
// Optional build macro: WB_CLIP_EXCLUDE_EN (drop clipped pixels from the sums).
module wb_coef_calc #(
    parameter  int unsigned PX_W        = 10,
    parameter  int unsigned FRAME_RES_X = 1920,
    parameter  int unsigned FRAME_RES_Y = 1080,
    parameter  int unsigned COEF_INT_W  = 4,
    parameter  int unsigned COEF_FRAC_W = 10,
    localparam int unsigned COEF_W      = COEF_INT_W + COEF_FRAC_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wb_ctrl_if.slave          wb_ctrl_i,
    input  logic              video_tvalid_i,
    input  logic              video_tready_i,
    input  logic [3*PX_W-1:0] video_tdata_i,
    input  logic              video_tuser_i,
    input  logic              video_tlast_i,
    output logic [COEF_W-1:0] coef_r_o,
    output logic [COEF_W-1:0] coef_g_o,
    output logic [COEF_W-1:0] coef_b_o,
    output logic              coef_upd_o,
    output logic              busy_o
);

    localparam int unsigned ACC_W  = PX_W + $clog2(FRAME_RES_X * FRAME_RES_Y);
    localparam int unsigned LINE_W = $clog2(FRAME_RES_Y + 1);
    localparam int unsigned CNT_W  = $clog2(COEF_W + 1);
    localparam int unsigned DVD_W  = ACC_W + COEF_FRAC_W;
    localparam logic [COEF_W-1:0] UNITY = COEF_W'(1) << COEF_FRAC_W;

    typedef enum logic [1:0] {
        MODE_MAN  = 2'd0,
        MODE_CAL  = 2'd1,
        MODE_CONT = 2'd2,
        MODE_BYP  = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_ACCUM,
        S_DIV_R,
        S_DIV_B,
        S_UPDATE
    } state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_sum_r;
    logic [ACC_W-1:0]    r_sum_g;
    logic [ACC_W-1:0]    r_sum_b;
    logic [LINE_W-1:0]   r_line;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_rem;
    logic [ACC_W-1:0]    r_divisor;
    logic [COEF_W-1:0]   r_dshift;
    logic [COEF_W-1:0]   r_quot;
    logic                r_sat;
    logic [COEF_W-1:0]   r_res_r;
    logic [COEF_W-1:0]   r_res_b;
    logic [COEF_W-1:0]   r_auto_r;
    logic [COEF_W-1:0]   r_auto_g;
    logic [COEF_W-1:0]   r_auto_b;
    logic [COEF_W-1:0]   r_man_r;
    logic [COEF_W-1:0]   r_man_g;
    logic [COEF_W-1:0]   r_man_b;
    logic                r_man_lock_d;

    logic                w_beat;
    logic [PX_W-1:0]     w_px_r;
    logic [PX_W-1:0]     w_px_g;
    logic [PX_W-1:0]     w_px_b;
    logic [ACC_W-1:0]    w_add_r;
    logic [ACC_W-1:0]    w_add_g;
    logic [ACC_W-1:0]    w_add_b;
    logic                w_abort;
    logic                w_start;
    logic [ACC_W-1:0]    w_den;
    logic [DVD_W-1:0]    w_dividend;
    logic [ACC_W-1:0]    w_rem_init;
    logic [ACC_W+COEF_INT_W-1:0] w_g_ext;
    logic [ACC_W+COEF_INT_W-1:0] w_den_sh;
    logic                w_sat;
    logic [ACC_W:0]      w_trial;
    logic                w_ge;
    logic [ACC_W:0]      w_trial_sub;
    logic [ACC_W-1:0]    w_rem_next;
    logic [COEF_W-1:0]   w_quot_next;
    logic [COEF_W-1:0]   w_res;
    logic                w_div_last;
    logic                w_upd_now;
    logic [COEF_W-1:0]   w_auto_r_nx;
    logic [COEF_W-1:0]   w_auto_g_nx;
    logic [COEF_W-1:0]   w_auto_b_nx;
    logic [COEF_W-1:0]   w_out_r;
    logic [COEF_W-1:0]   w_out_g;
    logic [COEF_W-1:0]   w_out_b;
    logic                w_man_load;
    logic                w_unused_man;

    // ---------------------------------------------------------------
    // Stream snooping
    // ---------------------------------------------------------------
    assign w_beat = video_tvalid_i && video_tready_i;
    assign w_px_r = video_tdata_i[3*PX_W-1 -: PX_W];
    assign w_px_g = video_tdata_i[2*PX_W-1 -: PX_W];
    assign w_px_b = video_tdata_i[PX_W-1:0];

`ifdef WB_CLIP_EXCLUDE_EN
    logic w_clip;
    assign w_clip  = (w_px_r == '1) || (w_px_g == '1) || (w_px_b == '1);
    assign w_add_r = w_clip ? '0 : ACC_W'(w_px_r);
    assign w_add_g = w_clip ? '0 : ACC_W'(w_px_g);
    assign w_add_b = w_clip ? '0 : ACC_W'(w_px_b);
`else
    assign w_add_r = ACC_W'(w_px_r);
    assign w_add_g = ACC_W'(w_px_g);
    assign w_add_b = ACC_W'(w_px_b);
`endif

    assign w_abort = (wb_ctrl_i.mode == MODE_MAN) || (wb_ctrl_i.mode == MODE_BYP);
    assign w_start = (wb_ctrl_i.mode == MODE_CONT) ||
                     ((wb_ctrl_i.mode == MODE_CAL) && wb_ctrl_i.cal_stb);

    // ---------------------------------------------------------------
    // Restoring divider datapath: (sum_g << FRAC) / den, MSB first.
    // Since the pre-check guarantees sum_g < den << INT, the quotient fits
    // COEF_W bits and the top of the dividend can be preloaded as the
    // initial remainder, leaving COEF_W dividend bits to shift in.
    // ---------------------------------------------------------------
    assign w_den       = (r_state == S_DIV_R) ? r_sum_r : r_sum_b;
    assign w_dividend  = {r_sum_g, {COEF_FRAC_W{1'b0}}};
    assign w_rem_init  = ACC_W'(w_dividend[DVD_W-1:COEF_W]);
    assign w_g_ext     = {{COEF_INT_W{1'b0}}, r_sum_g};
    assign w_den_sh    = {w_den, {COEF_INT_W{1'b0}}};
    assign w_sat       = (w_den == '0) || (w_g_ext >= w_den_sh);

    assign w_trial     = {r_rem, r_dshift[COEF_W-1]};
    assign w_ge        = w_trial >= {1'b0, r_divisor};
    assign w_trial_sub = w_trial - {1'b0, r_divisor};
    assign w_rem_next  = w_ge ? w_trial_sub[ACC_W-1:0] : w_trial[ACC_W-1:0];
    assign w_quot_next = {r_quot[COEF_W-2:0], w_ge};
    assign w_res       = r_sat ? '1 : w_quot_next;
    assign w_div_last  = (r_cnt == CNT_W'(COEF_W));

    // Main control FSM: frame accumulation, two serial divisions, auto update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_sum_r   <= '0;
            r_sum_g   <= '0;
            r_sum_b   <= '0;
            r_line    <= '0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_dshift  <= '0;
            r_quot    <= '0;
            r_sat     <= 1'b0;
            r_res_r   <= UNITY;
            r_res_b   <= UNITY;
            r_auto_r  <= UNITY;
            r_auto_g  <= UNITY;
            r_auto_b  <= UNITY;
        end else if ((r_state != S_IDLE) && w_abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_WAIT_SOF;
                    end
                end
                S_WAIT_SOF: begin
                    if (w_beat && video_tuser_i) begin
                        r_sum_r <= w_add_r;
                        r_sum_g <= w_add_g;
                        r_sum_b <= w_add_b;
                        r_line  <= '0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        if (video_tuser_i) begin
                            r_sum_r <= w_add_r;
                            r_sum_g <= w_add_g;
                            r_sum_b <= w_add_b;
                            r_line  <= '0;
                        end else begin
                            r_sum_r <= r_sum_r + w_add_r;
                            r_sum_g <= r_sum_g + w_add_g;
                            r_sum_b <= r_sum_b + w_add_b;
                            if (video_tlast_i) begin
                                if (r_line == LINE_W'(FRAME_RES_Y - 1)) begin
                                    r_state <= S_DIV_R;
                                    r_cnt   <= '0;
                                end else begin
                                    r_line <= r_line + 1'b1;
                                end
                            end
                        end
                    end
                end
                S_DIV_R, S_DIV_B: begin
                    if (r_cnt == '0) begin
                        r_divisor <= w_den;
                        r_rem     <= w_rem_init;
                        r_dshift  <= w_dividend[COEF_W-1:0];
                        r_quot    <= '0;
                        r_sat     <= w_sat;
                        r_cnt     <= CNT_W'(1);
                    end else begin
                        r_rem    <= w_rem_next;
                        r_dshift <= {r_dshift[COEF_W-2:0], 1'b0};
                        r_quot   <= w_quot_next;
                        if (w_div_last) begin
                            r_cnt <= '0;
                            if (r_state == S_DIV_R) begin
                                r_res_r <= w_res;
                                r_state <= S_DIV_B;
                            end else begin
                                r_res_b <= w_res;
                                r_state <= S_UPDATE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_UPDATE: begin
                    r_auto_r <= r_res_r;
                    r_auto_g <= UNITY;
                    r_auto_b <= r_res_b;
                    r_state  <= (wb_ctrl_i.mode == MODE_CONT) ? S_WAIT_SOF : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (r_state != S_IDLE);

    // ---------------------------------------------------------------
    // Manual coefficient registers
    // ---------------------------------------------------------------
    assign w_man_load   = wb_ctrl_i.man_lock && !r_man_lock_d;
    assign w_unused_man = ^wb_ctrl_i.man_coef[31:COEF_W];

    // Load the selected manual register on a rising edge of man_lock
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_man_lock_d <= 1'b0;
            r_man_r      <= UNITY;
            r_man_g      <= UNITY;
            r_man_b      <= UNITY;
        end else begin
            r_man_lock_d <= wb_ctrl_i.man_lock;
            if (w_man_load) begin
                case (wb_ctrl_i.man_sel)
                    2'd0:    r_man_r <= wb_ctrl_i.man_coef[COEF_W-1:0];
                    2'd1:    r_man_g <= wb_ctrl_i.man_coef[COEF_W-1:0];
                    2'd2:    r_man_b <= wb_ctrl_i.man_coef[COEF_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Output mux
    // ---------------------------------------------------------------
    // The mux looks through the UPDATE write so the new gains reach the
    // outputs in the same edge that loads the auto registers.
    assign w_upd_now   = (r_state == S_UPDATE) && !w_abort;
    assign w_auto_r_nx = w_upd_now ? r_res_r : r_auto_r;
    assign w_auto_g_nx = w_upd_now ? UNITY   : r_auto_g;
    assign w_auto_b_nx = w_upd_now ? r_res_b : r_auto_b;

    // Select the gain source for the current mode
    always_comb begin
        w_out_r = UNITY;
        w_out_g = UNITY;
        w_out_b = UNITY;
        case (wb_ctrl_i.mode)
            MODE_MAN: begin
                w_out_r = r_man_r;
                w_out_g = r_man_g;
                w_out_b = r_man_b;
            end
            MODE_CAL, MODE_CONT: begin
                w_out_r = w_auto_r_nx;
                w_out_g = w_auto_g_nx;
                w_out_b = w_auto_b_nx;
            end
            default: ;
        endcase
    end

    // Register the gains and flag a change of any of them
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            coef_r_o   <= UNITY;
            coef_g_o   <= UNITY;
            coef_b_o   <= UNITY;
            coef_upd_o <= 1'b0;
        end else begin
            coef_r_o   <= w_out_r;
            coef_g_o   <= w_out_g;
            coef_b_o   <= w_out_b;
            coef_upd_o <= ({w_out_r, w_out_g, w_out_b} != {coef_r_o, coef_g_o, coef_b_o});
        end
    end

endmodule

// File: tb/tb_wb_coef_calc.sv
// tb_wb_coef_calc: scoreboard bench for wb_coef_calc on a 4x2 frame.
// Stimulus pushes the expected output update (values and cycle) into a
// queue; a negedge monitor pops and compares on each coef_upd_o pulse.
module tb_wb_coef_calc;
    localparam int NX    = 4;
    localparam int NY    = 2;
    localparam int NPIX  = NX * NY;
    localparam int CW    = 14;
    localparam int UNITY = 1024;
    localparam int SATV  = 16383;
    localparam int LAT   = 2 * CW + 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        video_tvalid_i;
    logic        video_tready_i;
    logic [29:0] video_tdata_i;
    logic        video_tuser_i;
    logic        video_tlast_i;
    logic [13:0] coef_r_o;
    logic [13:0] coef_g_o;
    logic [13:0] coef_b_o;
    logic        coef_upd_o;
    logic        busy_o;

    wb_ctrl_if ctrl ();

    wb_coef_calc #(
        .PX_W        (10),
        .FRAME_RES_X (NX),
        .FRAME_RES_Y (NY),
        .COEF_INT_W  (4),
        .COEF_FRAC_W (10)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wb_ctrl_i      (ctrl),
        .video_tvalid_i (video_tvalid_i),
        .video_tready_i (video_tready_i),
        .video_tdata_i  (video_tdata_i),
        .video_tuser_i  (video_tuser_i),
        .video_tlast_i  (video_tlast_i),
        .coef_r_o       (coef_r_o),
        .coef_g_o       (coef_g_o),
        .coef_b_o       (coef_b_o),
        .coef_upd_o     (coef_upd_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int r;
        int g;
        int b;
        int at;
    } exp_t;
    exp_t exp_q[$];

    int m_mode;
    int m_auto[3];
    int m_man[3];
    int m_out[3];
    int fr_r[NPIX];
    int fr_g[NPIX];
    int fr_b[NPIX];

    // Gray-world gain with saturation, in plain integer arithmetic
    function automatic int gain(input longint num, input longint den);
        longint q;
        if (den == 0) return SATV;
        q = (num * 1024) / den;
        if (q > SATV) return SATV;
        return int'(q);
    endfunction

    task automatic calc_frame(output int gr, output int gb);
        longint sr, sg, sb;
        sr = 0; sg = 0; sb = 0;
        for (int i = 0; i < NPIX; i++) begin
`ifdef WB_CLIP_EXCLUDE_EN
            if (fr_r[i] == 1023 || fr_g[i] == 1023 || fr_b[i] == 1023) continue;
`endif
            sr += fr_r[i];
            sg += fr_g[i];
            sb += fr_b[i];
        end
        gr = gain(sg, sr);
        gb = gain(sg, sb);
    endtask

    // Recompute model outputs; queue an update if they change
    task automatic expect_out(input int at);
        int n[3];
        for (int k = 0; k < 3; k++) begin
            case (m_mode)
                0:       n[k] = m_man[k];
                1, 2:    n[k] = m_auto[k];
                default: n[k] = UNITY;
            endcase
        end
        if (n[0] != m_out[0] || n[1] != m_out[1] || n[2] != m_out[2]) begin
            exp_q.push_back('{r: n[0], g: n[1], b: n[2], at: at});
            for (int k = 0; k < 3; k++) m_out[k] = n[k];
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst_i) begin
            if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missed_upd: got no pulse, required r=%0h g=%0h b=%0h at cycle %0d",
                         e.r, e.g, e.b, e.at);
            end
            if (coef_upd_o) begin
                n_tests++;
                if (exp_q.size() == 0 || exp_q[0].at != cyc) begin
                    n_fail++;
                    $display("FAIL unexpected_upd: got pulse r=%0h g=%0h b=%0h at cycle %0d, required none",
                             coef_r_o, coef_g_o, coef_b_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(coef_r_o) != e.r || int'(coef_g_o) != e.g || int'(coef_b_o) != e.b) begin
                        n_fail++;
                        $display("FAIL upd_value: got r=%0h g=%0h b=%0h required r=%0h g=%0h b=%0h at cycle %0d",
                                 coef_r_o, coef_g_o, coef_b_o, e.r, e.g, e.b, cyc);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until_neg(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic set_mode(input int m);
        @(posedge clk); #1;
        ctrl.mode = m[1:0];
        m_mode = m;
        expect_out(cyc + 1);
    endtask

    // One beat with random bubbles and backpressure; returns accept cycle
    task automatic send_beat(input int r, input int g, input int b,
                             input logic u, input logic l, output int acc);
        int tries = 0;
        do begin
            @(posedge clk); #1;
            tries++;
            if (tries < 6 && $urandom_range(0, 4) == 0) begin
                video_tvalid_i = 1'b0;
                video_tready_i = 1'($urandom_range(0, 1));
                video_tdata_i  = 30'($urandom);
                video_tuser_i  = 1'b1;
                video_tlast_i  = 1'b1;
            end else begin
                video_tvalid_i = 1'b1;
                video_tready_i = (tries >= 6) || ($urandom_range(0, 3) != 0);
                video_tdata_i  = {r[9:0], g[9:0], b[9:0]};
                video_tuser_i  = u;
                video_tlast_i  = l;
            end
        end while (!(video_tvalid_i && video_tready_i));
        acc = cyc;
    endtask

    task automatic send_frame(input int first, input int last, output int t);
        for (int i = first; i <= last; i++)
            send_beat(fr_r[i], fr_g[i], fr_b[i], (i == 0), ((i % NX) == NX - 1), t);
        @(posedge clk); #1;
        video_tvalid_i = 1'b0;
        video_tuser_i  = 1'b0;
        video_tlast_i  = 1'b0;
    endtask

    task automatic fill_const(input int r, input int g, input int b);
        for (int i = 0; i < NPIX; i++) begin
            fr_r[i] = r; fr_g[i] = g; fr_b[i] = b;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NPIX; i++) begin
            fr_r[i] = $urandom_range(1, 1022);
            fr_g[i] = $urandom_range(1, 1022);
            fr_b[i] = $urandom_range(1, 1022);
        end
    endtask

    // Full frame that is expected to produce a computed update
    task automatic frame_auto();
        int t, gr, gb;
        send_frame(0, NPIX - 1, t);
        calc_frame(gr, gb);
        m_auto[0] = gr; m_auto[1] = UNITY; m_auto[2] = gb;
        expect_out(t + LAT);
        while (cyc < t + LAT + 4) wait_cyc(1);
    endtask

    task automatic man_load(input int sel, input int c);
        int t;
        @(posedge clk); #1;
        ctrl.man_sel  = sel[1:0];
        ctrl.man_coef = ($urandom & 32'hFFFF_C000) | c;
        ctrl.man_lock = 1'b1;
        t = cyc;
        if (sel < 3) m_man[sel] = c;
        expect_out(t + 2);
        @(posedge clk); #1;
        ctrl.man_coef = $urandom;
        @(posedge clk); #1;
        ctrl.man_lock = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        int t, tm;
        rst_i          = 1'b1;
        ctrl.mode      = 2'd0;
        ctrl.cal_stb   = 1'b0;
        ctrl.man_sel   = 2'd0;
        ctrl.man_coef  = '0;
        ctrl.man_lock  = 1'b0;
        video_tvalid_i = 1'b0;
        video_tready_i = 1'b0;
        video_tdata_i  = '0;
        video_tuser_i  = 1'b0;
        video_tlast_i  = 1'b0;
        m_mode = 0;
        for (int k = 0; k < 3; k++) begin
            m_auto[k] = UNITY; m_man[k] = UNITY; m_out[k] = UNITY;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_coef_r", coef_r_o, UNITY);
        check("rst_coef_g", coef_g_o, UNITY);
        check("rst_coef_b", coef_b_o, UNITY);
        check("rst_upd", coef_upd_o, 0);
        check("rst_busy", busy_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        wait_cyc(2);

        // Continuous auto, constant frame, then identical frame (no pulse)
        set_mode(2);
        tm = cyc;
        wait_until_neg(tm + 1);
        check("busy_wait_sof", busy_o, 1);
        fill_const(100, 200, 50);
        frame_auto();
        check("const_r", coef_r_o, 'h800);
        check("const_g", coef_g_o, 'h400);
        check("const_b", coef_b_o, 'h1000);
        frame_auto();

        // Saturation cases
        fill_const(0, 200, 50);
        frame_auto();
        check("sat_r_zero", coef_r_o, SATV);
        fill_const(10, 255, 200);
        frame_auto();
        check("sat_r_ratio", coef_r_o, SATV);

        // Random frames with random bubbles/backpressure
        for (int n = 0; n < 4; n++) begin
            fill_rand();
            frame_auto();
        end

        // SOF mid-accumulation restarts the frame
        fill_const(900, 100, 900);
        send_frame(0, 4, t);
        fill_rand();
        frame_auto();

        // Abort to bypass in the middle of the second division
        fill_const(300, 300, 300);
        send_frame(0, NPIX - 1, t);
        while (cyc < t + 20) wait_cyc(1);
        ctrl.mode = 2'd3;
        m_mode = 3;
        tm = cyc;
        expect_out(tm + 1);
        wait_until_neg(tm + 1);
        check("abort_busy", busy_o, 0);
        check("abort_coef_r", coef_r_o, UNITY);
        wait_cyc(LAT + 4);
        set_mode(2);
        wait_cyc(4);

        // Manual loads: in auto mode (hidden), then in manual mode
        man_load(1, 'h2AB);
        set_mode(0);
        man_load(2, 'h300);
        man_load(3, 'h123);
        wait_cyc(3);
        check("man_r", coef_r_o, UNITY);
        check("man_g", coef_g_o, 'h2AB);
        check("man_b", coef_b_o, 'h300);
        man_load(0, $urandom_range(0, SATV));
        wait_cyc(3);

        // Calibrate-on-strobe: strobe mid-frame, one computation, then idle
        set_mode(1);
        fill_rand();
        send_frame(0, 2, t);
        @(posedge clk); #1;
        ctrl.cal_stb = 1'b1;
        @(posedge clk); #1;
        ctrl.cal_stb = 1'b0;
        @(negedge clk);
        check("cal_busy", busy_o, 1);
        send_frame(3, NPIX - 1, t);
        fill_rand();
        frame_auto();
        check("cal_idle_busy", busy_o, 0);
        fill_rand();
        send_frame(0, NPIX - 1, t);
        wait_cyc(LAT + 4);
        check("cal_hold_r", coef_r_o, m_out[0]);
        check("cal_hold_g", coef_g_o, m_out[1]);
        check("cal_hold_b", coef_b_o, m_out[2]);

        // Frame containing clipped components
        set_mode(2);
        fill_rand();
        fr_r[1] = 1023;
        fr_g[5] = 1023;
        fr_b[6] = 1023;
        frame_auto();

        // Reset in the middle of a frame
        fill_rand();
        send_frame(0, 4, t);
        @(posedge clk); #1;
        rst_i = 1'b1;
        #1;
        check("midrst_coef_r", coef_r_o, UNITY);
        check("midrst_coef_g", coef_g_o, UNITY);
        check("midrst_coef_b", coef_b_o, UNITY);
        check("midrst_busy", busy_o, 0);
        check("midrst_upd", coef_upd_o, 0);
        for (int k = 0; k < 3; k++) begin
            m_auto[k] = UNITY; m_man[k] = UNITY; m_out[k] = UNITY;
        end
        exp_q.delete();
        wait_cyc(2);
        rst_i = 1'b0;
        wait_cyc(2);
        fill_const(100, 200, 50);
        frame_auto();

        wait_cyc(5);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_coef_calc.md
# wb_coef_calc

Coefficient engine for the white-balance corrector, directly downstream of the white-balance CSR block. It consumes the `wb_ctrl_if` control bundle and snoops the RGB video stream entering the corrector. In auto/calibrate modes it accumulates per-channel frame sums and computes gray-world gains with a serial divider. In manual mode it latches software coefficients. It drives the three per-channel gains the multiplier stage applies.

## Interface
- `PX_W`, 10: bits per colour component.
- `FRAME_RES_X`, 1920: pixels per line.
- `FRAME_RES_Y`, 1080: lines per frame.
- `COEF_INT_W`, 4: integer bits of a gain.
- `COEF_FRAC_W`, 10: fractional bits of a gain; `COEF_W = COEF_INT_W + COEF_FRAC_W`.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `wb_ctrl_i`  `wb_ctrl_if.slave`  –  `mode[1:0]`, `cal_stb` (1-cycle pulse), `man_sel[1:0]`, `man_coef[31:0]`, `man_lock`.
- `video_tvalid_i`  in  1  stream valid (snoop only).
- `video_tready_i`  in  1  stream ready (snoop only).
- `video_tdata_i`  in  3*PX_W  pixel as {R, G, B}, with R in the MSBs.
- `video_tuser_i`  in  1  start of frame.
- `video_tlast_i`  in  1  end of line.
- `coef_r_o`, `coef_g_o`, `coef_b_o`  out  COEF_W  unsigned gains in UQ`COEF_INT_W`.`COEF_FRAC_W` format.
- `coef_upd_o`  out  1  one-cycle pulse when any `coef_*_o` value changes.
- `busy_o`  out  1  high when the FSM is not in IDLE.

## Operation
- A beat is accepted when `tvalid && tready`. Accumulators are `ACC_W = PX_W + $clog2(FRAME_RES_X*FRAME_RES_Y)` bits each: `sum_r`, `sum_g`, `sum_b`.
- Modes:
  - 0 = manual: outputs come from the manual registers.
  - 1 = calibrate-on-strobe: outputs come from the auto registers.
  - 2 = continuous auto: outputs come from the auto registers.
  - 3 = bypass: all outputs are unity (`1 << COEF_FRAC_W`).
- FSM states are IDLE, WAIT_SOF, ACCUM, DIV_R, DIV_B, UPDATE.
- IDLE → WAIT_SOF when mode is 2, or when mode is 1 and `cal_stb` is high. `cal_stb` is ignored in every other state and mode.
- WAIT_SOF ignores all beats until an accepted beat with tuser high. That beat initialises the sums to its own components, clears the line counter, and moves the FSM to ACCUM.
- In ACCUM, each accepted beat adds to the sums, and an accepted `tlast` increments the line counter. The frame ends when tlast is accepted on line `FRAME_RES_Y`; the FSM then goes to DIV_R. A tuser beat seen during ACCUM restarts accumulation from that beat.
- DIV_R computes `(sum_g << COEF_FRAC_W) / sum_r` with a restoring divider, one quotient bit per cycle, MSB first.
  - A pre-check runs first: if `sum_r == 0` or `sum_g >= (sum_r << COEF_INT_W)`, the result saturates to `2^COEF_W - 1`.
- DIV_B performs the same operation using `sum_b`. Each DIV state lasts exactly COEF_W+1 cycles: 1 pre-check/load cycle plus COEF_W iterations.
- UPDATE writes `auto_r`, `auto_b`, and `auto_g = unity`.
  - Mode 2: the FSM goes to WAIT_SOF.
  - Mode 1: the FSM goes to IDLE.
- If mode changes to 0 or 3 in any non-IDLE state, the FSM aborts to IDLE and the auto registers keep their values.
- Manual load: on a rising edge of `man_lock` (tracked with an internal delayed copy), `man_coef[COEF_W-1:0]` is loaded into manual register R, G or B for `man_sel` = 0, 1 or 2. `man_sel` = 3 is ignored. Loads happen in every mode.
- Output mux is registered. `coef_upd_o` pulses in the cycle the registered outputs take a new value, whether from a mode change, UPDATE or a manual load while in mode 0. It stays low if the value is unchanged.

## Timing
- Reset values:
  - FSM in IDLE.
  - Sums and line counter are 0.
  - Auto and manual registers are unity.
  - `coef_*_o` are unity.
  - `coef_upd_o` and `busy_o` are 0.
- Let the last frame beat be accepted in cycle T. `coef_*_o` then change, and `coef_upd_o` pulses, in cycle T+2*COEF_W+4.
- A manual load with `man_lock` rising in cycle T, in mode 0, appears on the outputs in cycle T+2.
- A mode change at cycle T takes effect on the outputs at T+1.
- The block never stalls the stream.
- Asserting reset mid-operation returns everything to the reset values immediately.

## Configuration
- `WB_CLIP_EXCLUDE_EN`:
  - Defined: accepted beats where any component equals `2^PX_W-1` are not added to the sums. They still count toward tlast/line tracking. If such a beat is the SOF beat, the sums start at 0.
  - Undefined: all accepted beats are accumulated.

## Test plan
- Reset with `COEF_FRAC_W`=10 and `COEF_INT_W`=4 → all `coef_*_o` = 0x400, `coef_upd_o` = 0, `busy_o` = 0.
- Mode 2, 4x2 frame, every pixel R=100, G=200, B=50 → `coef_r` = 0x800, `coef_g` = 0x400, `coef_b` = 0x1000 at T+32, with a single `coef_upd_o` pulse. A second identical frame produces no further pulse.
- Mode 2 frame with R=0 everywhere → `coef_r_o` = 0x3FFF (saturated). Frame with G=255, R=10 → `coef_r_o` = 0x3FFF.
- Mode 0 with `man_sel`=2, `man_coef`=0x300, `man_lock` 0→1 → `coef_b_o` = 0x300 two cycles later. `man_sel`=3 → no change.
- Mode 1, `cal_stb` pulse mid-frame → FSM waits for SOF, computes once, and returns to IDLE with `busy_o`=0. The next frame, with different data, leaves the outputs unchanged.
- tuser beat mid-ACCUM → result reflects only the restarted frame. Switching to mode 3 during DIV_B → outputs unity at T+1 and FSM in IDLE. With `WB_CLIP_EXCLUDE_EN`, clipped pixels are excluded from the result.
